burst_capture_unit: RTL and testbench

Parametrised successor to the single-channel capture/invert datapath. It accepts a start command with a programmable burst length and transform mode, then captures that many valid input samples. Each sample is transformed (pass, invert, XOR-mask or bit-reverse), driven out, and written into an addressable capture buffer. It sits between the stimulus source and the scope/checker logic, which reads the buffer back after the burst completes.

---
 rtl/burst_capture_unit.sv | 157 +++++++++++++++
 tb/tb_burst_capture_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_capture_unit.sv
// burst_capture_unit: captures a programmable burst of transformed samples
// into a wrapping buffer that is read back through a registered port.
module burst_capture_unit #(
   parameter int W     = 4,
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [CNT_W-1:0]         len,
   input  logic [1:0]               mode,
   input  logic [W-1:0]             mask,
   input  logic [W-1:0]             din,
   input  logic                     din_valid,
   input  logic                     abort,
   input  logic                     clr,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [W-1:0]             dout,
   output logic                     dout_valid,
   output logic [W-1:0]             rd_data,
   output logic                     busy,
   output logic                     done,
   output logic [CNT_W-1:0]         count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_CAPTURE = 2'b01,
      S_DONE    = 2'b10
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] len_q;
   logic [1:0]       mode_q;
   logic [W-1:0]     mask_q;
   logic [AW-1:0]    wptr_q;
   logic [W-1:0]     mem_q [DEPTH];

   logic             accept;
   logic             start_ok;
   logic [W-1:0]     t_din;
   logic [CNT_W-1:0] count_inc;
   logic             last;

   function automatic logic [W-1:0] xform(
      input logic [1:0]   m,
      input logic [W-1:0] d,
      input logic [W-1:0] k
   );
      logic [W-1:0] r;
      r = d;
      case (m)
         2'b00: r = d;
         2'b01: r = ~d;
         2'b10: r = d ^ k;
         2'b11: begin
            for (int i = 0; i < W; i++) begin
               r[i] = d[W-1-i];
            end
         end
         default: r = d;
      endcase
      return r;
   endfunction

   assign accept    = (state_q == S_CAPTURE) && din_valid && !abort;
   assign start_ok  = (state_q == S_IDLE) && start;
   assign t_din     = xform(mode_q, din, mask_q);
   assign count_inc = (count == '1) ? count : count + 1'b1;
   assign last      = (count_inc == len_q);

   assign busy = (state_q == S_CAPTURE);
   assign done = (state_q == S_DONE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (len == '0) ? S_DONE : S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (din_valid && last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (clr) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q      <= '0;
         mode_q     <= '0;
         mask_q     <= '0;
         wptr_q     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= accept;
         if (start_ok) begin
            len_q    <= len;
            mode_q   <= mode;
            mask_q   <= mask;
            wptr_q   <= '0;
            count    <= '0;
            overflow <= 1'b0;
         end else if (accept) begin
            dout   <= t_din;
            wptr_q <= wptr_q + 1'b1;
            count  <= count_inc;
            // the sample taking count past DEPTH has overwritten entry 0
            if (32'(count) == DEPTH) begin
               overflow <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_data <= '0;
      end else begin
         rd_data <= mem_q[rd_addr];
         if (accept) begin
            mem_q[wptr_q] <= t_din;
         end
      end
   end

endmodule

// File: tb/tb_burst_capture_unit.sv
// tb_burst_capture_unit: table-driven cycle vectors plus hand-written
// sequences for asynchronous reset mid-burst.
module tb_burst_capture_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] len;
   logic [1:0] mode;
   logic [3:0] mask;
   logic [3:0] din;
   logic       din_valid;
   logic       abort;
   logic       clr;
   logic [2:0] rd_addr;
   logic [3:0] dout;
   logic       dout_valid;
   logic [3:0] rd_data;
   logic       busy;
   logic       done;
   logic [7:0] count;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   burst_capture_unit #(.W(4), .DEPTH(8), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .mode       (mode),
      .mask       (mask),
      .din        (din),
      .din_valid  (din_valid),
      .abort      (abort),
      .clr        (clr),
      .rd_addr    (rd_addr),
      .dout       (dout),
      .dout_valid (dout_valid),
      .rd_data    (rd_data),
      .busy       (busy),
      .done       (done),
      .count      (count),
      .overflow   (overflow)
   );

   typedef struct {
      logic       st;
      logic [7:0] ln;
      logic [1:0] md;
      logic [3:0] mk;
      logic [3:0] d;
      logic       dv;
      logic       ab;
      logic       cl;
      logic [2:0] ra;
      logic [3:0] e_dout;
      logic       e_dval;
      logic       e_busy;
      logic       e_done;
      logic [7:0] e_cnt;
      logic       e_ovf;
      logic       chk_rd;
      logic [3:0] e_rd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(
      input int st, input int ln, input int md, input int mk,
      input int d, input int dv, input int ab, input int cl,
      input int ra,
      input int ed, input int ev, input int eb, input int edn,
      input int ec, input int eo, input int cr, input int er
   );
      vec_t r;
      r.st = st[0]; r.ln = 8'(ln); r.md = 2'(md);
      r.mk = 4'(mk); r.d = 4'(d); r.dv = dv[0];
      r.ab = ab[0]; r.cl = cl[0]; r.ra = 3'(ra);
      r.e_dout = 4'(ed); r.e_dval = ev[0]; r.e_busy = eb[0];
      r.e_done = edn[0]; r.e_cnt = 8'(ec); r.e_ovf = eo[0];
      r.chk_rd = cr[0]; r.e_rd = 4'(er);
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      start = 0; len = 0; mode = 0; mask = 0; din = 0;
      din_valid = 0; abort = 0; clr = 0; rd_addr = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_dout"}, int'(dout), 0);
      chk({tag, "_dval"}, int'(dout_valid), 0);
      chk({tag, "_rd"}, int'(rd_data), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_count"}, int'(count), 0);
      chk({tag, "_ovf"}, int'(overflow), 0);
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;

      // pass, len 3
      tbl.push_back(v(1,3,0,0,0,0,0,0,0, 0,0,1,0,0,0,1,0));
      tbl.push_back(v(0,0,0,0,1,1,0,0,0, 1,1,1,0,1,0,0,0));
      tbl.push_back(v(0,0,0,0,2,1,0,0,0, 2,1,1,0,2,0,0,0));
      tbl.push_back(v(0,0,0,0,3,1,0,0,0, 3,1,0,1,3,0,0,0));
      tbl.push_back(v(0,0,0,0,0,0,0,0,0, 3,0,0,1,3,0,1,1));
      tbl.push_back(v(0,0,0,0,0,0,0,0,1, 3,0,0,1,3,0,1,2));
      tbl.push_back(v(0,0,0,0,0,0,0,1,2, 3,0,0,0,3,0,1,3));
      // invert, len 2, gap of two cycles
      tbl.push_back(v(1,2,1,0,0,0,0,0,0, 3,0,1,0,0,0,0,0));
      tbl.push_back(v(0,0,0,0,3,1,0,0,0, 'hC,1,1,0,1,0,0,0));
      tbl.push_back(v(0,0,0,0,'hF,0,0,0,0, 'hC,0,1,0,1,0,0,0));
      tbl.push_back(v(0,0,0,0,'hF,0,0,0,0, 'hC,0,1,0,1,0,0,0));
      tbl.push_back(v(0,0,0,0,'hA,1,0,0,0, 5,1,0,1,2,0,0,0));
      tbl.push_back(v(0,0,0,0,0,0,0,1,0, 5,0,0,0,2,0,1,'hC));
      // xor mask F
      tbl.push_back(v(1,1,2,'hF,0,0,0,0,1, 5,0,1,0,0,0,1,5));
      tbl.push_back(v(0,0,0,0,6,1,0,0,0, 9,1,0,1,1,0,0,0));
      tbl.push_back(v(0,0,0,0,0,0,0,1,0, 9,0,0,0,1,0,1,9));
      // bit reverse
      tbl.push_back(v(1,1,3,0,0,0,0,0,0, 9,0,1,0,0,0,0,0));
      tbl.push_back(v(0,0,0,0,1,1,0,0,0, 8,1,0,1,1,0,0,0));
      tbl.push_back(v(0,0,0,0,0,0,0,1,0, 8,0,0,0,1,0,0,0));
      // len 10 over an 8-entry buffer
      tbl.push_back(v(1,10,0,0,0,0,0,0,0, 8,0,1,0,0,0,0,0));
      for (int k = 0; k < 10; k++) begin
         tbl.push_back(v(0,0,0,0,k,1,0,0,0,
                         k,1,int'(k < 9),int'(k == 9),k+1,
                         int'(k >= 8),0,0));
      end
      for (int i = 0; i < 8; i++) begin
         tbl.push_back(v(0,0,0,0,0,0,0,int'(i == 7),i,
                         9,0,0,int'(i != 7),10,1,1,
                         (i < 2) ? i + 8 : i));
      end
      // abort on third sample, then len 0 and DONE behaviour
      tbl.push_back(v(1,5,0,0,0,0,0,0,0, 9,0,1,0,0,0,0,0));
      tbl.push_back(v(0,0,0,0,'hA,1,0,0,0, 'hA,1,1,0,1,0,0,0));
      tbl.push_back(v(0,0,0,0,'hB,1,0,0,0, 'hB,1,1,0,2,0,0,0));
      tbl.push_back(v(0,0,0,0,'hC,1,1,0,0, 'hB,0,0,0,2,0,0,0));
      tbl.push_back(v(0,0,0,0,0,0,0,0,2, 'hB,0,0,0,2,0,1,2));
      tbl.push_back(v(0,0,0,0,0,0,0,0,0, 'hB,0,0,0,2,0,1,'hA));
      tbl.push_back(v(1,0,0,0,0,0,0,0,0, 'hB,0,0,1,0,0,0,0));
      tbl.push_back(v(1,3,0,0,0,0,0,0,0, 'hB,0,0,1,0,0,0,0));
      tbl.push_back(v(0,0,0,0,'hF,1,0,0,0, 'hB,0,0,1,0,0,0,0));
      tbl.push_back(v(0,0,0,0,0,0,0,1,0, 'hB,0,0,0,0,0,0,0));
      tbl.push_back(v(0,0,0,0,5,1,1,1,0, 'hB,0,0,0,0,0,0,0));

      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;

      foreach (tbl[i]) begin
         start = tbl[i].st; len = tbl[i].ln; mode = tbl[i].md;
         mask = tbl[i].mk; din = tbl[i].d; din_valid = tbl[i].dv;
         abort = tbl[i].ab; clr = tbl[i].cl; rd_addr = tbl[i].ra;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_dout", i), int'(dout), int'(tbl[i].e_dout));
         chk($sformatf("v%0d_dval", i), int'(dout_valid), int'(tbl[i].e_dval));
         chk($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
         chk($sformatf("v%0d_done", i), int'(done), int'(tbl[i].e_done));
         chk($sformatf("v%0d_count", i), int'(count), int'(tbl[i].e_cnt));
         chk($sformatf("v%0d_ovf", i), int'(overflow), int'(tbl[i].e_ovf));
         if (tbl[i].chk_rd) begin
            chk($sformatf("v%0d_rd", i), int'(rd_data), int'(tbl[i].e_rd));
         end
      end
      idle_inputs();

      // asynchronous reset after two of four samples
      start = 1; len = 4;
      @(posedge clk); #1;
      start = 0; len = 0; din = 3; din_valid = 1;
      @(posedge clk); #1;
      din = 5;
      @(posedge clk); #1;
      din_valid = 0;
      chk("pre_rst_count", int'(count), 2);
      chk("pre_rst_dout", int'(dout), 5);
      #3 rst = 1'b1;
      #1;
      chk_zero("async_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd_addr = 3'(i);
         @(posedge clk); #1;
         chk($sformatf("rst_buf%0d", i), int'(rd_data), 0);
      end
      rd_addr = 0;
      start = 1; len = 1;
      @(posedge clk); #1;
      start = 0; len = 0;
      chk("post_rst_busy", int'(busy), 1);
      din = 7; din_valid = 1;
      @(posedge clk); #1;
      din_valid = 0;
      chk("post_rst_dout", int'(dout), 7);
      chk("post_rst_dval", int'(dout_valid), 1);
      chk("post_rst_done", int'(done), 1);
      chk("post_rst_count", int'(count), 1);
      clr = 1;
      @(posedge clk); #1;
      clr = 0;
      chk("post_rst_rd0", int'(rd_data), 7);
      chk("post_rst_clr", int'(done), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
